spi_peripheral_responder: RTL and testbench

SPI peripheral (slave) responder: the far end of the SoC's spi0 master link, used to emulate an SPI device or bridge a second SoC. It oversamples the SCLK, MOSI and SS_n inputs on the system clock and delivers received words on a valid-pulse interface. It shifts out words from a one-entry transmit holding register. Fixed to SPI mode 0 (CPOL=0, CPHA=0), MSB first.

---
 rtl/spi_peripheral_responder.sv | 184 ++++++++++++++++++
 tb/tb_spi_peripheral_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_peripheral_responder.sv
// ---------------------------------------------------------------------------
// spi_peripheral_responder
// SPI peripheral (slave) for mode 0 (CPOL=0, CPHA=0), MSB first. SCLK, MOSI
// and SS_n are oversampled on clk_clk. Received words are delivered as
// rx_data with a one-cycle rx_valid pulse. Transmit words come from a
// one-entry holding register written through a tx_valid/tx_ready handshake.
//
// Ports
//   clk_clk, reset_reset_n          system clock, async active-low reset
//   spi0_SCLK/MOSI/SS_n             SPI inputs from the master
//   spi0_MISO, spi0_MISO_oe         SPI output data and its output enable
//   tx_data/tx_valid/tx_ready       transmit holding-register write port
//   rx_data/rx_valid                last received word, update pulse
//   tx_underrun                     pulse: word started with hold empty
//   rx_frame_abort                  pulse: SS_n released mid-word
// ---------------------------------------------------------------------------
module spi_peripheral_responder #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic              spi0_SCLK,
   input  logic              spi0_MOSI,
   input  logic              spi0_SS_n,
   output logic              spi0_MISO,
   output logic              spi0_MISO_oe,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              tx_underrun,
   output logic              rx_frame_abort
);

   localparam int unsigned CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

   typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

   state_t r_state, w_state_nxt;

   logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_ss_sync;
   logic                   r_sclk_d, r_ss_d;
   logic                   r_started, r_armed;
   logic [CNT_W-1:0]       r_bit_cnt;
   logic [DATA_W-2:0]      r_rx_shift;
   logic [DATA_W-1:0]      r_tx_shift;
   logic [DATA_W-1:0]      r_hold;
   logic                   r_hold_full;

   logic              w_sclk, w_mosi, w_ss;
   logic              w_rise, w_fall, w_ss_fall, w_ss_rise;
   logic              w_active, w_word_done, w_load, w_accept;
   logic [DATA_W-1:0] w_rx_next;

   // Input synchronisers plus one delay flop for edge detection
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_sclk_sync <= '0;
         r_mosi_sync <= '0;
         r_ss_sync   <= '1;
         r_sclk_d    <= 1'b0;
         r_ss_d      <= 1'b1;
         r_started   <= 1'b0;
         r_armed     <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi0_SCLK};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi0_MOSI};
         r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], spi0_SS_n};
         r_sclk_d    <= w_sclk;
         r_ss_d      <= w_ss;
         r_started   <= 1'b1;
         // Arm only once a genuine high SS_n sample is seen after reset, so a
         // frame already in progress at reset release is ignored.
         r_armed     <= r_armed | (r_started & r_ss_sync[0]);
      end
   end

   assign w_sclk    = r_sclk_sync[SYNC_STAGES-1];
   assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
   assign w_ss      = r_ss_sync[SYNC_STAGES-1];
   assign w_rise    = w_sclk & ~r_sclk_d;
   assign w_fall    = ~w_sclk & r_sclk_d;
   assign w_ss_fall = ~w_ss & r_ss_d & r_armed;
   assign w_ss_rise = w_ss & ~r_ss_d;

   assign w_active    = (r_state == ST_ACTIVE);
   assign w_word_done = w_active & w_rise & (r_bit_cnt == LAST);
   // A word finishing together with SS_n release completes but loads nothing
   assign w_load      = (~w_active & w_ss_fall) | (w_word_done & ~w_ss_rise);
   assign w_accept    = tx_valid & ~r_hold_full;
   assign w_rx_next   = {r_rx_shift, w_mosi};
   assign tx_ready    = ~r_hold_full;

   // FSM: state register
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) r_state <= ST_IDLE;
      else                r_state <= w_state_nxt;
   end

   // FSM: next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (w_ss_fall) w_state_nxt = ST_ACTIVE;
         ST_ACTIVE: if (w_ss_rise) w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      spi0_MISO    = 1'b1;
      spi0_MISO_oe = 1'b0;
      if (r_state == ST_ACTIVE) begin
         spi0_MISO    = r_tx_shift[DATA_W-1];
         spi0_MISO_oe = 1'b1;
      end
   end

   // Datapath: holding register, shifters, bit counter, status pulses
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_hold         <= '0;
         r_hold_full    <= 1'b0;
         r_tx_shift     <= '1;
         r_rx_shift     <= '0;
         r_bit_cnt      <= '0;
         rx_data        <= '0;
         rx_valid       <= 1'b0;
         tx_underrun    <= 1'b0;
         rx_frame_abort <= 1'b0;
      end else begin
         rx_valid       <= 1'b0;
         tx_underrun    <= 1'b0;
         rx_frame_abort <= 1'b0;

         // An accept coinciding with an underrun load stays in hold
         if (w_load && r_hold_full) begin
            r_hold_full <= 1'b0;
         end else if (w_accept) begin
            r_hold      <= tx_data;
            r_hold_full <= 1'b1;
         end

         // Falls at bit_cnt==0 are skipped to keep the freshly loaded MSB
         if (w_active && w_fall && r_bit_cnt != '0)
            r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b1};

         if (w_load) begin
            if (r_hold_full) begin
               r_tx_shift <= r_hold;
            end else begin
               r_tx_shift  <= '1;
               tx_underrun <= 1'b1;
            end
         end

         if (!w_active) begin
            if (w_ss_fall) r_bit_cnt <= '0;
         end else if (w_ss_rise) begin
            if (w_word_done) begin
               rx_data  <= w_rx_next;
               rx_valid <= 1'b1;
            end else if (r_bit_cnt != '0) begin
               rx_frame_abort <= 1'b1;
            end
            r_bit_cnt <= '0;
         end else if (w_rise) begin
            if (w_word_done) begin
               rx_data   <= w_rx_next;
               rx_valid  <= 1'b1;
               r_bit_cnt <= '0;
            end else begin
               r_rx_shift <= w_rx_next[DATA_W-2:0];
               r_bit_cnt  <= r_bit_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_peripheral_responder.sv
// ---------------------------------------------------------------------------
// tb_spi_peripheral_responder
// Directed bench: a mode-0 SPI master (SCLK = clk/10) drives the responder,
// captures MISO, and checks received words, handshake and status pulses.
// ---------------------------------------------------------------------------
module tb_spi_peripheral_responder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sclk = 1'b0, mosi = 1'b0, ss_n = 1'b1;
   logic       miso, miso_oe;
   logic [7:0] tx_data = '0;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid, tx_underrun, rx_frame_abort;

   int checks = 0;
   int errors = 0;
   int n_rxv = 0, n_und = 0, n_abt = 0;
   logic [7:0] rx_hist[$];

   always #5 clk = ~clk;

   spi_peripheral_responder #(.DATA_W(8), .SYNC_STAGES(2)) dut (
      .clk_clk        (clk),
      .reset_reset_n  (rst_n),
      .spi0_SCLK      (sclk),
      .spi0_MOSI      (mosi),
      .spi0_SS_n      (ss_n),
      .spi0_MISO      (miso),
      .spi0_MISO_oe   (miso_oe),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .tx_underrun    (tx_underrun),
      .rx_frame_abort (rx_frame_abort)
   );

   // Pulse monitor
   always @(negedge clk) begin
      if (rx_valid) begin
         n_rxv++;
         rx_hist.push_back(rx_data);
      end
      if (tx_underrun)    n_und++;
      if (rx_frame_abort) n_abt++;
   end

   initial begin
      #500us;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic offer(input logic [7:0] d);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic frame_start();
      ss_n = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   // One word; with last=1 SS_n rises together with the final SCLK rise
   task automatic xfer(input logic [7:0] m, input bit last, output logic [7:0] s);
      for (int i = 7; i >= 0; i--) begin
         mosi = m[i];
         repeat (5) @(negedge clk);
         sclk = 1'b1;
         s[i] = miso;
         if (last && i == 0) ss_n = 1'b1;
         repeat (5) @(negedge clk);
         sclk = 1'b0;
      end
      if (last) repeat (10) @(negedge clk);
   endtask

   task automatic bits(input int n);
      for (int i = 0; i < n; i++) begin
         mosi = 1'b1;
         repeat (5) @(negedge clk);
         sclk = 1'b1;
         repeat (5) @(negedge clk);
         sclk = 1'b0;
      end
   endtask

   initial begin
      logic [7:0] s0, s1;
      int rx0, und0, abt0;

      // ---- Reset with random SPI pins ----
      for (int k = 0; k < 6; k++) begin
         {sclk, mosi, ss_n} = 3'($urandom);
         @(negedge clk);
         chk("rst_miso", miso, 1);
         chk("rst_oe", miso_oe, 0);
         chk("rst_tx_ready", tx_ready, 1);
         chk("rst_rx_data", rx_data, 0);
         chk("rst_pulses", {rx_valid, tx_underrun, rx_frame_abort}, 0);
      end
      sclk = 1'b0; mosi = 1'b0; ss_n = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      bits(4);
      repeat (10) @(negedge clk);
      chk("idle_no_rx", n_rxv, 0);
      chk("idle_miso", miso, 1);
      chk("idle_oe", miso_oe, 0);

      // ---- Single word ----
      offer(8'hA5);
      chk("single_hold_full", tx_ready, 0);
      rx0 = n_rxv; und0 = n_und;
      frame_start();
      chk("single_oe", miso_oe, 1);
      chk("single_tx_ready", tx_ready, 1);
      xfer(8'h3C, 1'b1, s0);
      chk("single_miso_word", s0, 8'hA5);
      chk("single_rx_data", rx_data, 8'h3C);
      chk("single_rx_count", n_rxv - rx0, 1);
      chk("single_underrun", n_und - und0, 0);
      chk("single_oe_after", miso_oe, 0);

      // ---- Back-to-back ----
      offer(8'h11);
      rx0 = n_rxv; und0 = n_und;
      frame_start();
      offer(8'h22);
      xfer(8'hC3, 1'b0, s0);
      xfer(8'h5A, 1'b1, s1);
      chk("b2b_miso_w0", s0, 8'h11);
      chk("b2b_miso_w1", s1, 8'h22);
      chk("b2b_rx_count", n_rxv - rx0, 2);
      chk("b2b_rx_w0", rx_hist[rx0], 8'hC3);
      chk("b2b_rx_w1", rx_hist[rx0+1], 8'h5A);
      chk("b2b_underrun", n_und - und0, 0);
      chk("b2b_tx_ready", tx_ready, 1);

      // ---- Underrun ----
      rx0 = n_rxv; und0 = n_und;
      frame_start();
      xfer(8'h81, 1'b0, s0);
      xfer(8'h7F, 1'b1, s1);
      chk("und_miso_w0", s0, 8'hFF);
      chk("und_miso_w1", s1, 8'hFF);
      chk("und_count", n_und - und0, 2);
      chk("und_rx_count", n_rxv - rx0, 2);
      chk("und_rx_w0", rx_hist[rx0], 8'h81);
      chk("und_rx_w1", rx_hist[rx0+1], 8'h7F);

      // ---- Abort after 3 bits ----
      rx0 = n_rxv; abt0 = n_abt;
      frame_start();
      bits(3);
      repeat (5) @(negedge clk);
      ss_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("abort_count", n_abt - abt0, 1);
      chk("abort_no_rx", n_rxv - rx0, 0);
      chk("abort_oe", miso_oe, 0);
      chk("abort_miso", miso, 1);
      rx0 = n_rxv;
      frame_start();
      xfer(8'h96, 1'b1, s0);
      chk("post_abort_rx", rx_data, 8'h96);
      chk("post_abort_rx_count", n_rxv - rx0, 1);

      // ---- Reset mid-word ----
      offer(8'h42);
      frame_start();
      offer(8'h24);
      bits(4);
      rst_n = 1'b0;
      #1;
      chk("midrst_oe", miso_oe, 0);
      chk("midrst_miso", miso, 1);
      chk("midrst_tx_ready", tx_ready, 1);
      chk("midrst_rx_data", rx_data, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      rx0 = n_rxv;
      repeat (8) @(negedge clk);
      bits(8);
      repeat (10) @(negedge clk);
      chk("stale_frame_oe", miso_oe, 0);
      chk("stale_frame_rx", n_rxv - rx0, 0);
      ss_n = 1'b1;
      repeat (10) @(negedge clk);
      und0 = n_und;
      frame_start();
      xfer(8'h7E, 1'b1, s0);
      chk("midrst_rx", rx_data, 8'h7E);
      chk("midrst_miso_word", s0, 8'hFF);
      chk("midrst_underrun", n_und - und0, 1);
      chk("midrst_rx_count", n_rxv - rx0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
